// File: rtl/alu_cmd_sequencer.sv
// Command sequencer for the combinational 8-bit ALU: a FIFO of commands feeds a registered
// issue slot that drives the ALU, and a registered result stage captures its output.
module alu_cmd_sequencer #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 8
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         cmd_valid,
   output logic                         cmd_ready,
   input  logic [WIDTH-1:0]             cmd_a,
   input  logic [WIDTH-1:0]             cmd_b,
   input  logic [WIDTH-1:0]             cmd_c,
   input  logic [WIDTH-1:0]             cmd_d,
   input  logic [3:0]                   cmd_opcode,
   input  logic                         cmd_sel,
   input  logic                         flush,
   output logic [WIDTH-1:0]             alu_a,
   output logic [WIDTH-1:0]             alu_b,
   output logic [WIDTH-1:0]             alu_c,
   output logic [WIDTH-1:0]             alu_d,
   output logic [3:0]                   alu_opcode,
   output logic                         alu_sel,
   input  logic [WIDTH-1:0]             alu_result,
   input  logic                         alu_zero,
   output logic                         res_valid,
   input  logic                         res_ready,
   output logic [WIDTH-1:0]             res_data,
   output logic                         res_zero,
   output logic                         res_err,
   output logic [$clog2(DEPTH+1)-1:0]   fifo_count,
   output logic                         busy
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);
   localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

   typedef struct packed {
      logic [WIDTH-1:0] a;
      logic [WIDTH-1:0] b;
      logic [WIDTH-1:0] c;
      logic [WIDTH-1:0] d;
      logic [3:0]       opcode;
      logic             sel;
   } cmd_t;

   cmd_t             r_mem [DEPTH];
   logic [PW-1:0]    r_wrPtr;
   logic [PW-1:0]    r_rdPtr;
   logic [CW-1:0]    r_count;
   logic             r_issueValid;
   cmd_t             r_issue;
   logic             r_resValid;
   logic [WIDTH-1:0] r_resData;
   logic             r_resZero;
   logic             r_resErr;

   cmd_t             w_incoming;
   logic             w_push;
   logic             w_pop;
   logic             w_retire;
   logic             w_drain;
   logic             w_fifoEmpty;

   assign w_incoming  = '{a: cmd_a, b: cmd_b, c: cmd_c, d: cmd_d,
                          opcode: cmd_opcode, sel: cmd_sel};
   assign w_fifoEmpty = (r_count == '0);

   // A full FIFO refuses new commands even when the head is leaving this cycle.
   assign cmd_ready = !flush && (r_count < FULL_COUNT);
   assign w_push    = cmd_valid && cmd_ready;
   assign w_retire  = r_issueValid && (!r_resValid || res_ready) && !flush;
   assign w_pop     = (!r_issueValid || w_retire) && !w_fifoEmpty && !flush;
   assign w_drain   = r_resValid && res_ready && !w_retire;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_mem[i] <= '0;
         end
      end else if (w_push) begin
         r_mem[r_wrPtr] <= w_incoming;
      end
   end

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wrPtr <= '0;
         r_rdPtr <= '0;
         r_count <= '0;
      end else if (flush) begin
         r_wrPtr <= '0;
         r_rdPtr <= '0;
         r_count <= '0;
      end else begin
         if (w_push) begin
            r_wrPtr <= r_wrPtr + PW'(1);
         end
         if (w_pop) begin
            r_rdPtr <= r_rdPtr + PW'(1);
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // The operand registers keep their last command when the slot empties.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_issueValid <= 1'b0;
         r_issue      <= '0;
      end else if (flush) begin
         r_issueValid <= 1'b0;
      end else if (w_pop) begin
         r_issueValid <= 1'b1;
         r_issue      <= r_mem[r_rdPtr];
      end else if (w_retire) begin
         r_issueValid <= 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_resValid <= 1'b0;
         r_resData  <= '0;
         r_resZero  <= 1'b0;
         r_resErr   <= 1'b0;
      end else if (w_retire) begin
         r_resValid <= 1'b1;
         r_resData  <= alu_result;
         r_resZero  <= alu_zero;
         r_resErr   <= (r_issue.opcode > 4'b0111);
      end else if (w_drain) begin
         r_resValid <= 1'b0;
      end
   end

   assign alu_a      = r_issue.a;
   assign alu_b      = r_issue.b;
   assign alu_c      = r_issue.c;
   assign alu_d      = r_issue.d;
   assign alu_opcode = r_issue.opcode;
   assign alu_sel    = r_issue.sel;

   assign res_valid  = r_resValid;
   assign res_data   = r_resData;
   assign res_zero   = r_resZero;
   assign res_err    = r_resErr;
   assign fifo_count = r_count;
   assign busy       = !w_fifoEmpty || r_issueValid || r_resValid;

endmodule
